// File: rtl/ysyx_22040127_fetch.sv
// Instruction-fetch stage: keeps the fetch PC, issues single-outstanding word reads,
// and buffers {inst, pc} pairs in a small FIFO toward decode; redirects flush and cancel.
module ysyx_22040127_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_allowin,
    output logic        if_to_id_valid,
    output logic [63:0] if_to_id_bus,
    input  logic        id_br_valid,
    input  logic [31:0] id_br_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_rdata
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_pc;
    logic          r_outstanding;
    logic          r_cancel;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [63:0]   r_fifo [DEPTH];

    logic          w_resp;
    logic          w_pop;
    logic          w_push;
    logic          w_req_fire;
    logic          w_credit;
    logic [CW:0]   w_level;
    logic          w_unused_tgt_lsb;

    assign w_resp         = imem_resp_valid & r_outstanding;
    assign if_to_id_valid = (r_count != '0) & ~id_br_valid;
    assign w_pop          = if_to_id_valid & id_allowin;
    assign w_push         = w_resp & ~r_cancel & ~id_br_valid;

    // Credit counts buffered entries plus the read in flight, so a returning word always has a slot.
    assign w_level  = {1'b0, r_count} + {{CW{1'b0}}, r_outstanding} - {{CW{1'b0}}, w_pop};
    assign w_credit = w_level < DEPTH_L;

    assign imem_req_valid   = rst & ~id_br_valid & (~r_outstanding | w_resp) & w_credit;
    assign imem_addr        = r_fetch_pc;
    assign w_req_fire       = imem_req_valid & imem_req_ready;
    assign if_to_id_bus     = r_fifo[r_head];
    assign w_unused_tgt_lsb = ^id_br_target[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= '0;
            r_outstanding <= 1'b0;
            r_cancel      <= 1'b0;
            r_count       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else if (id_br_valid) begin
            r_fetch_pc <= {id_br_target[31:2], 2'b00};
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            // A read landing in the redirect cycle simply retires; otherwise it must be discarded later.
            if (w_resp) begin
                r_outstanding <= 1'b0;
                r_cancel      <= 1'b0;
            end else if (r_outstanding) begin
                r_cancel <= 1'b1;
            end
        end else begin
            if (w_req_fire) begin
                r_req_pc      <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 32'd4;
                r_outstanding <= 1'b1;
            end else if (w_resp) begin
                r_outstanding <= 1'b0;
            end
            if (w_resp & r_cancel) begin
                r_cancel <= 1'b0;
            end
            if (w_push) begin
                r_fifo[r_tail] <= {imem_rdata, r_req_pc};
                r_tail         <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (w_push & ~w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop & ~w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        (w_push && !w_pop) |-> (r_count != DEPTH_L[CW-1:0]));

endmodule

// File: tb/tb_ysyx_22040127_fetch.sv
// Bench for the fetch stage: a latency-configurable memory responder feeds a scoreboard of
// expected {inst, pc} pairs; a monitor pops and compares at every decode handshake.
module tb_ysyx_22040127_fetch;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_allowin = 1'b0;
    logic        if_to_id_valid;
    logic [63:0] if_to_id_bus;
    logic        id_br_valid = 1'b0;
    logic [31:0] id_br_target = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_rdata = '0;

    ysyx_22040127_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .id_allowin(id_allowin),
        .if_to_id_valid(if_to_id_valid), .if_to_id_bus(if_to_id_bus),
        .id_br_valid(id_br_valid), .id_br_target(id_br_target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid), .imem_rdata(imem_rdata)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [63:0] sb_q[$];
    logic [31:0] exp_req = RESET_PC;
    logic [63:0] exp_e;
    int          pops = 0;
    logic [31:0] last_pop_pc = '0;
    bit          mem_busy = 1'b0;
    int          mem_left = 0;
    logic [31:0] mem_addr = '0;
    bit          resp_now;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          rnd_ready = 1'b0;
    bit          prev_hold = 1'b0;
    bit          prev_br = 1'b0;
    logic [63:0] prev_bus = '0;
    int          p0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder plus scoreboard monitor; everything settles by negedge+1.
    always @(negedge clk) begin
        if (!rst) begin
            imem_resp_valid = 1'b0;
            imem_req_ready  = 1'b0;
            if (mem_busy) mem_left = 0;   // abandoned read returns right after release
            sb_q.delete();
            exp_req = RESET_PC;
            #1;
            chk("rst_if_valid", 64'(if_to_id_valid), 64'd0);
            chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
            chk("rst_bus", if_to_id_bus, 64'd0);
            prev_hold = 1'b0;
            prev_br   = 1'b0;
        end else begin
            resp_now        = mem_busy && (mem_left == 0);
            imem_resp_valid = resp_now;
            imem_rdata      = resp_now ? word_at(mem_addr) : $urandom;
            imem_req_ready  = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (resp_now) mem_busy = 1'b0;
            else if (mem_busy) mem_left--;
            if (imem_req_valid && imem_req_ready) begin
                chk("one_outstanding", 64'(mem_busy), 64'd0);
                chk("req_addr", 64'(imem_addr), 64'(exp_req));
                sb_q.push_back({word_at(exp_req), exp_req});
                exp_req  = exp_req + 32'd4;
                mem_busy = 1'b1;
                mem_addr = imem_addr;
                mem_left = int'($urandom_range(lat_min, lat_max)) - 1;
            end
            if (prev_br) chk("empty_after_redirect", 64'(if_to_id_valid), 64'd0);
            if (prev_hold && !id_br_valid) begin
                chk("hold_valid", 64'(if_to_id_valid), 64'd1);
                chk("hold_bus", if_to_id_bus, prev_bus);
            end
            if (id_br_valid) begin
                chk("br_blocks_output", 64'(if_to_id_valid), 64'd0);
                chk("br_blocks_req", 64'(imem_req_valid), 64'd0);
                sb_q.delete();
                exp_req = {id_br_target[31:2], 2'b00};
            end else if (if_to_id_valid && id_allowin) begin
                chk("pop_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    exp_e = sb_q.pop_front();
                    chk("bus", if_to_id_bus, exp_e);
                end
                last_pop_pc = if_to_id_bus[31:0];
                pops++;
            end
            chk("credit_bound", 64'(sb_q.size() <= DEPTH), 64'd1);
            prev_hold = if_to_id_valid && !id_allowin && !id_br_valid;
            prev_bus  = if_to_id_bus;
            prev_br   = id_br_valid;
        end
    end

    task automatic cyc(input bit allow);
        @(negedge clk);
        id_allowin  = allow;
        id_br_valid = 1'b0;
    endtask

    // Pulse a redirect in a cycle where the in-flight read does (or does not) return.
    task automatic redirect_when(input bit want_resp, input logic [31:0] tgt);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (mem_busy && ((mem_left == 0) == want_resp)) break;
            id_br_valid = 1'b0;
            id_allowin  = 1'b1;
            n++;
            if (n > 50) begin
                chk("redirect_window_timeout", 64'(n), 64'd0);
                return;
            end
        end
        id_allowin   = 1'b1;
        id_br_target = tgt;
        id_br_valid  = 1'b1;
    endtask

    task automatic expect_first_pop(input string name, input logic [31:0] pc);
        int start;
        int n;
        start = pops;
        n = 0;
        while (pops == start && n < 40) begin
            cyc(1'b1);
            #2;
            n++;
        end
        chk({name, "_seen"}, 64'(pops != start), 64'd1);
        if (pops != start) chk(name, 64'(last_pop_pc), 64'(pc));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        id_allowin = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;

        // streaming with zero-wait memory
        p0 = pops;
        cyc(1'b1);
        #2;
        chk("first_req_valid", 64'(imem_req_valid), 64'd1);
        chk("first_req_addr", 64'(imem_addr), 64'(RESET_PC));
        repeat (19) cyc(1'b1);
        #2;
        chk("zero_wait_throughput", 64'(pops - p0), 64'd18);

        // decode stall
        repeat (6) cyc(1'b0);
        #2;
        chk("stall_no_req", 64'(imem_req_valid), 64'd0);
        chk("stall_valid", 64'(if_to_id_valid), 64'd1);
        chk("stall_full", 64'(sb_q.size()), 64'(DEPTH));
        repeat (10) cyc(1'b1);

        // redirect while a slow read is in flight
        lat_min = 3; lat_max = 3;
        repeat (4) cyc(1'b1);
        redirect_when(1'b0, 32'h8000_0104);
        expect_first_pop("cancel_redirect_pc", 32'h8000_0104);
        repeat (6) cyc(1'b1);

        // redirect coinciding with the response
        lat_min = 2; lat_max = 2;
        repeat (4) cyc(1'b1);
        redirect_when(1'b1, 32'h8000_0300);
        expect_first_pop("resp_redirect_pc", 32'h8000_0300);

        // misaligned target
        lat_min = 1; lat_max = 1;
        repeat (3) cyc(1'b1);
        redirect_when(1'b1, 32'h8000_0206);
        expect_first_pop("aligned_target_pc", 32'h8000_0204);
        repeat (4) cyc(1'b1);

        // asynchronous reset with buffered entries and a read in flight
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0);
            #2;
            if (mem_busy && if_to_id_valid) break;
        end
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_valid", 64'(if_to_id_valid), 64'd0);
        chk("async_rst_req", 64'(imem_req_valid), 64'd0);
        chk("async_rst_bus", if_to_id_bus, 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        lat_min = 1; lat_max = 1;
        id_allowin = 1'b1;
        #3 rst = 1'b1;
        expect_first_pop("restart_pc", RESET_PC);
        repeat (5) cyc(1'b1);

        // randomized traffic
        rnd_ready = 1'b1;
        lat_min = 1; lat_max = 4;
        p0 = pops;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            id_allowin   = ($urandom_range(0, 3) != 0);
            id_br_valid  = ($urandom_range(0, 15) == 0);
            id_br_target = $urandom;
        end
        rnd_ready = 1'b0;
        repeat (20) cyc(1'b1);
        #2;
        chk("random_progress", 64'((pops - p0) >= 30), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
